// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard
// ----------------------------------------------------------------------------
// Parametrised register file with a T flag and a per-register busy scoreboard.
// Decode reads operands and marks destinations pending. Writeback writes
// results and clears the pending bit. A pending bit is how decode detects a
// RAW hazard on a producer that is still in flight, such as a load.
//
// Register map (default NUM_REGS = 13):
//   0-7 R0-R7, 8 SP, 9 EPC, 10 ESP, 11 IH, 12 RA.
//
// Ports:
//   clock           rising-edge clock for all state
//   reset           asynchronous active-low reset (registers, T, busy -> 0)
//   rd_addr         NUM_READ read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data         NUM_READ read results,   port i at [i*DATA_W +: DATA_W]
//   rd_busy         per-port pending-producer flag for the addressed register
//   wr_en/wr_addr/wr_data  single write port; the write also clears busy
//   t_wr_en/t_wr_data      T flag write
//   t_rd            current T flag (bypassed when BYPASS = 1)
//   busy_set_en/busy_set_addr  mark a register as having a pending producer
//   busy            scoreboard vector, bit k = register k
//   debug_registers stored register contents, register 0 in the MSBs
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 13,
    parameter int ADDR_W   = 4,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         t_wr_en,
    input  logic                         t_wr_data,
    output logic                         t_rd,
    input  logic                         busy_set_en,
    input  logic [ADDR_W-1:0]            busy_set_addr,
    output logic [NUM_REGS-1:0]          busy,
    output logic [NUM_REGS*DATA_W-1:0]   debug_registers
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                tFlag;
    logic [NUM_REGS-1:0] busyQ;

    // One-hot decodes. An address at or above NUM_REGS matches no k, so
    // out-of-range writes and busy sets fall away with no side effects.
    logic [NUM_REGS-1:0] wrSel;
    logic [NUM_REGS-1:0] setSel;
    logic [NUM_REGS-1:0] bypassSel;

    always_comb begin
        wrSel  = '0;
        setSel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wrSel[k]  = wr_en && (wr_addr == ADDR_W'(k));
            setSel[k] = busy_set_en && (busy_set_addr == ADDR_W'(k));
        end
    end

    // Forwarding is suppressed while reset is held so that reads return the
    // cleared state immediately, not a write that is about to be discarded.
    assign bypassSel = (BYPASS != 0) ? (wrSel & {NUM_REGS{reset}}) : '0;

    // ------------------------------------------------------------------
    // State update: registers, T flag, scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
            tFlag <= 1'b0;
            busyQ <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wrSel[k]) begin
                    regs[k] <= wr_data;
                end
                // A set in the same cycle as the clearing write means a new
                // producer was issued, so the set has priority.
                if (setSel[k]) begin
                    busyQ[k] <= 1'b1;
                end else if (wrSel[k]) begin
                    busyQ[k] <= 1'b0;
                end
            end
            if (t_wr_en) begin
                tFlag <= t_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(k)) begin
                    if (bypassSel[k]) begin
                        // The write retires this edge, so the hazard is gone.
                        rd_data[i*DATA_W +: DATA_W] = wr_data;
                        rd_busy[i]                  = 1'b0;
                    end else begin
                        rd_data[i*DATA_W +: DATA_W] = regs[k];
                        rd_busy[i]                  = busyQ[k];
                    end
                end
            end
        end
    end

    assign t_rd = ((BYPASS != 0) && t_wr_en && reset) ? t_wr_data : tFlag;
    assign busy = busyQ;

    always_comb begin
        debug_registers = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            debug_registers[(NUM_REGS-1-k)*DATA_W +: DATA_W] = regs[k];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    // Shared stimulus for the default-parameter pair (BYPASS=1 and BYPASS=0)
    logic [7:0]   rdAddr;
    logic         wrEn;
    logic [3:0]   wrAddr;
    logic [15:0]  wrData;
    logic         tWrEn;
    logic         tWrData;
    logic         busySetEn;
    logic [3:0]   busySetAddr;

    logic [31:0]  rdDataA,  rdDataB;
    logic [1:0]   rdBusyA,  rdBusyB;
    logic         tRdA,     tRdB;
    logic [12:0]  busyA,    busyB;
    logic [207:0] debugA,   debugB;

    // Wide configuration for the sweep
    logic [11:0]  sRdAddr;
    logic [95:0]  sRdData;
    logic [2:0]   sRdBusy;
    logic         sWrEn;
    logic [3:0]   sWrAddr;
    logic [31:0]  sWrData;
    logic         sTWrEn;
    logic         sTWrData;
    logic         sTRd;
    logic         sBusySetEn;
    logic [3:0]   sBusySetAddr;
    logic [15:0]  sBusy;
    logic [511:0] sDebug;

    int passCount  = 0;
    int checkCount = 0;

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(13), .ADDR_W(4), .NUM_READ(2), .BYPASS(1)) dutA (
        .clock(clock), .reset(reset), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_busy(rdBusyA),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .t_wr_en(tWrEn), .t_wr_data(tWrData),
        .t_rd(tRdA), .busy_set_en(busySetEn), .busy_set_addr(busySetAddr), .busy(busyA),
        .debug_registers(debugA));

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(13), .ADDR_W(4), .NUM_READ(2), .BYPASS(0)) dutB (
        .clock(clock), .reset(reset), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .t_wr_en(tWrEn), .t_wr_data(tWrData),
        .t_rd(tRdB), .busy_set_en(busySetEn), .busy_set_addr(busySetAddr), .busy(busyB),
        .debug_registers(debugB));

    regfile_scoreboard #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_READ(3), .BYPASS(1)) dutS (
        .clock(clock), .reset(reset), .rd_addr(sRdAddr), .rd_data(sRdData), .rd_busy(sRdBusy),
        .wr_en(sWrEn), .wr_addr(sWrAddr), .wr_data(sWrData), .t_wr_en(sTWrEn), .t_wr_data(sTWrData),
        .t_rd(sTRd), .busy_set_en(sBusySetEn), .busy_set_addr(sBusySetAddr), .busy(sBusy),
        .debug_registers(sDebug));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        wrEn = 1'b0; wrAddr = '0; wrData = '0;
        tWrEn = 1'b0; tWrData = 1'b0;
        busySetEn = 1'b0; busySetAddr = '0;
    endtask

    task automatic test_reset();
        // Outputs during the initial reset
        rdAddr = {4'd3, 4'd0};
        #2;
        checkCount++;
        if (rdDataA !== 32'h0 || tRdA !== 1'b0 || busyA !== 13'h0 || debugA !== 208'h0)
            $display("FAIL reset_initial rd=%h t=%b busy=%h (want 0/0/0)", rdDataA, tRdA, busyA);
        else passCount++;

        @(negedge clock);
        reset = 1'b1;
        // Load reg[3]=0x1234, T=1, busy[3]
        wrEn = 1'b1; wrAddr = 4'd3; wrData = 16'h1234;
        tWrEn = 1'b1; tWrData = 1'b1;
        busySetEn = 1'b1; busySetAddr = 4'd3;
        step();
        idleInputs();
        rdAddr = {4'd3, 4'd3};
        #1;
        checkCount++;
        if (rdDataA !== 32'h1234_1234 || tRdA !== 1'b1 || busyA !== 13'h0008)
            $display("FAIL reset_preload rd=%h t=%b busy=%h (want 12341234/1/0008)", rdDataA, tRdA, busyA);
        else passCount++;

        // Mid-cycle reset with a pending write; must clear before the next edge
        wrEn = 1'b1; wrAddr = 4'd3; wrData = 16'h5555;
        tWrEn = 1'b1; tWrData = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        checkCount++;
        if (rdDataA !== 32'h0 || tRdA !== 1'b0 || busyA !== 13'h0)
            $display("FAIL reset_async_bypass rd=%h t=%b busy=%h (want 0/0/0)", rdDataA, tRdA, busyA);
        else passCount++;
        checkCount++;
        if (rdDataB !== 32'h0 || tRdB !== 1'b0 || busyB !== 13'h0)
            $display("FAIL reset_async_nobypass rd=%h t=%b busy=%h (want 0/0/0)", rdDataB, tRdB, busyB);
        else passCount++;

        // Edge while reset held: write and busy set ignored
        busySetEn = 1'b1; busySetAddr = 4'd3;
        step();
        checkCount++;
        if (debugA !== 208'h0 || busyA !== 13'h0 || tRdA !== 1'b0)
            $display("FAIL reset_held_write busy=%h t=%b debugNonZero=%b (want 0/0/0)", busyA, tRdA, |debugA);
        else passCount++;
        idleInputs();
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic test_write();
        wrEn = 1'b1; wrAddr = 4'd12; wrData = 16'hBEEF;
        step();
        wrAddr = 4'd13; wrData = 16'hFFFF;
        busySetEn = 1'b1; busySetAddr = 4'd14;
        rdAddr = {4'd13, 4'd12};
        #1;
        checkCount++;
        if (rdDataA !== 32'h0000_BEEF)
            $display("FAIL write_oor_no_forward rd=%h want 0000beef", rdDataA);
        else passCount++;
        step();
        idleInputs();
        #1;
        checkCount++;
        if (rdDataA !== 32'h0000_BEEF || rdDataB !== 32'h0000_BEEF)
            $display("FAIL write_readback A=%h B=%h want 0000beef", rdDataA, rdDataB);
        else passCount++;
        checkCount++;
        if (debugA !== 208'hBEEF || debugB !== 208'hBEEF)
            $display("FAIL write_debug A=%h B=%h want ...beef", debugA[31:0], debugB[31:0]);
        else passCount++;
        checkCount++;
        if (busyA !== 13'h0)
            $display("FAIL write_oor_busy_set busy=%h want 0000", busyA);
        else passCount++;
        // Both ports on the same register
        rdAddr = {4'd12, 4'd12};
        #1;
        checkCount++;
        if (rdDataA !== 32'hBEEF_BEEF)
            $display("FAIL same_reg_two_ports rd=%h want beefbeef", rdDataA);
        else passCount++;
    endtask

    task automatic test_bypass();
        wrEn = 1'b1; wrAddr = 4'd5; wrData = 16'hA5A5;
        tWrEn = 1'b1; tWrData = 1'b1;
        rdAddr = {4'd12, 4'd5};
        #1;
        checkCount++;
        if (rdDataA[15:0] !== 16'hA5A5 || tRdA !== 1'b1)
            $display("FAIL bypass_before_edge rd=%h t=%b want a5a5/1", rdDataA[15:0], tRdA);
        else passCount++;
        checkCount++;
        if (rdDataB[15:0] !== 16'h0000 || tRdB !== 1'b0)
            $display("FAIL nobypass_before_edge rd=%h t=%b want 0000/0", rdDataB[15:0], tRdB);
        else passCount++;
        step();
        idleInputs();
        #1;
        checkCount++;
        if (rdDataA[15:0] !== 16'hA5A5 || rdDataB[15:0] !== 16'hA5A5)
            $display("FAIL write_after_edge A=%h B=%h want a5a5", rdDataA[15:0], rdDataB[15:0]);
        else passCount++;
        // T holds its value with the enable low
        step();
        checkCount++;
        if (tRdA !== 1'b1 || tRdB !== 1'b1)
            $display("FAIL t_hold A=%b B=%b want 1", tRdA, tRdB);
        else passCount++;
        tWrEn = 1'b1; tWrData = 1'b0;
        step();
        idleInputs();
        #1;
        checkCount++;
        if (tRdA !== 1'b0 || tRdB !== 1'b0)
            $display("FAIL t_clear A=%b B=%b want 0", tRdA, tRdB);
        else passCount++;
    endtask

    task automatic test_scoreboard();
        busySetEn = 1'b1; busySetAddr = 4'd2;
        step();
        idleInputs();
        rdAddr = {4'd2, 4'd5};
        #1;
        checkCount++;
        if (rdBusyA !== 2'b10 || busyA !== 13'h0004)
            $display("FAIL busy_set rdBusy=%b busy=%h want 10/0004", rdBusyA, busyA);
        else passCount++;
        // Write and set on the same register in one cycle
        wrEn = 1'b1; wrAddr = 4'd2; wrData = 16'h0777;
        busySetEn = 1'b1; busySetAddr = 4'd2;
        #1;
        checkCount++;
        if (rdBusyA !== 2'b00 || rdBusyB !== 2'b10)
            $display("FAIL busy_bypass_force A=%b B=%b want 00/10", rdBusyA, rdBusyB);
        else passCount++;
        step();
        idleInputs();
        #1;
        checkCount++;
        if (busyA !== 13'h0004 || busyB !== 13'h0004)
            $display("FAIL busy_set_wins A=%h B=%h want 0004", busyA, busyB);
        else passCount++;
        // Different addresses in one cycle
        wrEn = 1'b1; wrAddr = 4'd2; wrData = 16'h0888;
        busySetEn = 1'b1; busySetAddr = 4'd7;
        step();
        idleInputs();
        #1;
        checkCount++;
        if (busyA !== 13'h0080)
            $display("FAIL busy_set_clear_diff busy=%h want 0080", busyA);
        else passCount++;
        wrEn = 1'b1; wrAddr = 4'd7; wrData = 16'h0001;
        step();
        idleInputs();
        rdAddr = {4'd7, 4'd2};
        #1;
        checkCount++;
        if (busyA !== 13'h0 || rdBusyA !== 2'b00 || rdDataA !== 32'h0001_0888)
            $display("FAIL busy_clear busy=%h rdBusy=%b rd=%h want 0000/00/00010888", busyA, rdBusyA, rdDataA);
        else passCount++;
        // Out-of-range read address reports no hazard and zero data
        busySetEn = 1'b1; busySetAddr = 4'd12;
        step();
        idleInputs();
        rdAddr = {4'd15, 4'd12};
        #1;
        checkCount++;
        if (rdBusyA !== 2'b01 || rdDataA[31:16] !== 16'h0)
            $display("FAIL busy_oor_read rdBusy=%b rd1=%h want 01/0000", rdBusyA, rdDataA[31:16]);
        else passCount++;
    endtask

    task automatic test_sweep();
        logic [31:0] mRegs [16];
        logic        mT;
        logic [15:0] mBusy;
        logic [95:0] expData;
        logic [2:0]  expBusy;
        logic        expT;
        logic [3:0]  a;
        int          errs;

        // Fresh state for the wide instance: the others reset alongside it
        reset = 1'b0;
        sWrEn = 1'b0; sTWrEn = 1'b0; sBusySetEn = 1'b0;
        step();
        @(negedge clock);
        reset = 1'b1;
        step();
        for (int k = 0; k < 16; k++) mRegs[k] = '0;
        mT = 1'b0;
        mBusy = '0;
        errs = 0;

        for (int c = 0; c < 10000; c++) begin
            sWrEn        = ($urandom_range(0, 3) != 0);
            sWrAddr      = 4'($urandom_range(0, 15));
            sWrData      = $urandom;
            sTWrEn       = ($urandom_range(0, 2) == 0);
            sTWrData     = 1'($urandom_range(0, 1));
            sBusySetEn   = ($urandom_range(0, 1) == 0);
            sBusySetAddr = 4'($urandom_range(0, 15));
            sRdAddr      = 12'($urandom_range(0, 4095));
            #2;
            for (int i = 0; i < 3; i++) begin
                a = sRdAddr[i*4 +: 4];
                if (sWrEn && sWrAddr == a) begin
                    expData[i*32 +: 32] = sWrData;
                    expBusy[i] = 1'b0;
                end else begin
                    expData[i*32 +: 32] = mRegs[a];
                    expBusy[i] = mBusy[a];
                end
            end
            expT = sTWrEn ? sTWrData : mT;

            checkCount++;
            if (sRdData !== expData) begin
                if (errs < 10) $display("FAIL sweep_rd_data cycle %0d got %h want %h", c, sRdData, expData);
                errs++;
            end else passCount++;
            checkCount++;
            if (sRdBusy !== expBusy) begin
                if (errs < 10) $display("FAIL sweep_rd_busy cycle %0d got %b want %b", c, sRdBusy, expBusy);
                errs++;
            end else passCount++;
            checkCount++;
            if (sTRd !== expT) begin
                if (errs < 10) $display("FAIL sweep_t_rd cycle %0d got %b want %b", c, sTRd, expT);
                errs++;
            end else passCount++;
            checkCount++;
            if (sBusy !== mBusy) begin
                if (errs < 10) $display("FAIL sweep_busy cycle %0d got %h want %h", c, sBusy, mBusy);
                errs++;
            end else passCount++;

            if (sWrEn) begin
                mRegs[sWrAddr] = sWrData;
                mBusy[sWrAddr] = 1'b0;
            end
            if (sBusySetEn) mBusy[sBusySetAddr] = 1'b1;
            if (sTWrEn) mT = sTWrData;
            step();
        end
        sWrEn = 1'b0; sTWrEn = 1'b0; sBusySetEn = 1'b0;
    endtask

    initial begin
        idleInputs();
        rdAddr = '0;
        sRdAddr = '0; sWrEn = 1'b0; sWrAddr = '0; sWrData = '0;
        sTWrEn = 1'b0; sTWrData = 1'b0; sBusySetEn = 1'b0; sBusySetAddr = '0;

        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_sweep();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
